// File: rtl/fb_pkg.sv
// fb_pkg: shared widths, depth and encodings for the framebuffer port arbiter
package fb_pkg;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;
  localparam int FB_DEPTH = 307200;
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DONE = 2'd2} fill_state_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_VGA, GNT_CPU, GNT_FILL} gnt_e;
endpackage

// File: rtl/fb_fill_engine.sv
// fb_fill_engine: clear-screen engine writing one colour to addresses 0..DEPTH-1 when granted
module fb_fill_engine
  import fb_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W,
  parameter int DEPTH = FB_DEPTH
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          fill_start_i,
  input  logic [DW-1:0] fill_color_i,
  input  logic          grant_i,
  output logic          req_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_o,
  output logic          busy_o,
  output logic          done_o
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  fill_state_e state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] col_q, col_d;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      col_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      col_q <= col_d;
    end
  end
  // a start pulse is only honoured from IDLE, so the colour cannot be re-latched mid-fill
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    col_d = col_q;
    case (state_q)
      IDLE: if (fill_start_i) begin
        state_d = FILL;
        cnt_d = '0;
        col_d = fill_color_i;
      end
      FILL: if (grant_i) begin
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == LAST) ? DONE : FILL;
      end
      default: state_d = IDLE;
    endcase
  end
  assign req_o = state_q == FILL;
  assign busy_o = req_o;
  assign done_o = state_q == DONE;
  assign addr_o = cnt_q;
  assign data_o = col_q;
endmodule

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: single framebuffer port shared by VGA reads (fixed priority), CPU writes and fill.
// Optional FB_STATS_EN builds a saturating CPU stall counter; otherwise cpu_stall_cnt is 0.
module fb_port_arbiter #(
  parameter int ADDR_W = fb_pkg::ADDR_W,
  parameter int DATA_W = fb_pkg::DATA_W,
  parameter int FB_DEPTH = fb_pkg::FB_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rvalid,
  input  logic              cpu_wr_valid,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic              cpu_wr_ready,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [15:0]       cpu_stall_cnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);
  import fb_pkg::*;
  gnt_e gnt;
  logic rr_q, rr_d;
  logic vga_rvalid_q;
  logic fill_req, fill_gnt, contend;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;
  fb_fill_engine #(.AW(ADDR_W), .DW(DATA_W), .DEPTH(FB_DEPTH)) u_fill (
    .clock(clock),
    .reset(reset),
    .fill_start_i(fill_start),
    .fill_color_i(fill_color),
    .grant_i(fill_gnt),
    .req_o(fill_req),
    .addr_o(fill_addr),
    .data_o(fill_data),
    .busy_o(fill_busy),
    .done_o(fill_done)
  );
  // rr_q=0 favours the CPU on the next contention, rr_q=1 favours the fill engine
  always_comb begin
    contend = !vga_req && cpu_wr_valid && fill_req;
    gnt = vga_req ? GNT_VGA : contend ? (rr_q ? GNT_FILL : GNT_CPU) :
          cpu_wr_valid ? GNT_CPU : fill_req ? GNT_FILL : GNT_NONE;
    rr_d = contend ? (gnt == GNT_CPU) : rr_q;
  end
  assign cpu_wr_ready = gnt == GNT_CPU;
  assign fill_gnt = gnt == GNT_FILL;
  assign mem_addr = cpu_wr_ready ? cpu_wr_addr : fill_gnt ? fill_addr : vga_addr;
  assign mem_wdata = fill_gnt ? fill_data : cpu_wr_data;
  assign mem_we = (cpu_wr_ready && ({1'b0, cpu_wr_addr} < (ADDR_W + 1)'(FB_DEPTH))) || fill_gnt;
  assign vga_rdata = mem_rdata;
  assign vga_rvalid = vga_rvalid_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_q <= 1'b0;
      vga_rvalid_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
      vga_rvalid_q <= vga_req;
    end
  end
`ifdef FB_STATS_EN
  logic [15:0] stall_q, stall_d;
  assign stall_d = (cpu_wr_valid && !cpu_wr_ready && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign cpu_stall_cnt = stall_q;
`else
  assign cpu_stall_cnt = '0;
`endif
endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Arbitrates the single port of the VGA framebuffer RAM between three requesters: the VGA scan-out read (vga_controller), processor pixel writes, and a built-in hardware fill (clear-screen) engine.
- Sits between the processor/vga_controller and the framebuffer memory in skeleton.
- VGA reads always win, so scan-out is never starved. The processor and the fill engine share the remaining cycles round-robin.

Parameters:
- ADDR_W, 19, framebuffer address width.
- DATA_W, 8, palette index width.
- FB_DEPTH, 307200, number of valid pixels (640x480); addresses >= FB_DEPTH are out of range.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- vga_req  in  1  VGA read request this cycle.
- vga_addr  in  ADDR_W  VGA read address.
- vga_rdata  out  DATA_W  read data; equals mem_rdata.
- vga_rvalid  out  1  vga_rdata is valid; asserted 1 cycle after a vga_req.
- cpu_wr_valid  in  1  processor write request.
- cpu_wr_addr  in  ADDR_W  processor write address.
- cpu_wr_data  in  DATA_W  processor write data.
- cpu_wr_ready  out  1  write accepted this cycle.
- fill_start  in  1  single-cycle pulse that starts a fill.
- fill_color  in  DATA_W  fill colour; sampled on an accepted fill_start.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-cycle pulse after the last fill write.
- cpu_stall_cnt  out  16  cycles in which the processor write was stalled (see Optional Feature).
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  DATA_W  RAM read data; synchronous read, 1-cycle latency.

Behaviour:
- Interface: one clock (clock); asynchronous active-high reset (reset).
- Reset values: vga_rvalid=0, fill_busy=0, fill_done=0, cpu_stall_cnt=0, fill counter=0, round-robin pointer=CPU. Reset mid-fill aborts the fill with no fill_done pulse.
- Grant logic is combinational each cycle:
  - If vga_req: mem_addr=vga_addr, mem_we=0, cpu_wr_ready=0, no fill write.
  - Else if cpu_wr_valid and fill_busy both contend: the round-robin pointer picks the winner, then the pointer flips to the loser.
  - Else the single requester wins. The pointer is unchanged when there is no contention.
- CPU grant:
  - cpu_wr_ready=1, mem_addr=cpu_wr_addr, mem_wdata=cpu_wr_data.
  - mem_we=1 only if cpu_wr_addr < FB_DEPTH. An out-of-range write is still acknowledged but dropped.
  - Handshake: a transfer occurs when cpu_wr_valid && cpu_wr_ready. The processor holds its address and data until the transfer.
  - cpu_wr_ready never depends on cpu_wr_ready itself, and is 0 whenever cpu_wr_valid=0.
- Fill state machine:
  - IDLE: fill_start latches fill_color, clears the counter, moves to FILL, and sets fill_busy=1 on the next cycle.
  - FILL: on each granted cycle, write colour to address counter and increment the counter. When the write to FB_DEPTH-1 is granted, move to DONE.
  - DONE: fill_done=1 for one cycle, fill_busy=0, return to IDLE.
  - fill_start while busy or in DONE is ignored, and the colour is not re-latched.
  - A fill of N pixels with no contention takes exactly N cycles in FILL.
- VGA read: vga_rvalid is vga_req registered. vga_rdata passes mem_rdata through, so data is valid in the cycle after the request.
- Simultaneous CPU write and fill write to the same address: they occur in different cycles by construction; the last writer wins.
- No combinational path from mem_rdata to any control output.

Optional Feature:
- FB_STATS_EN defined: cpu_stall_cnt increments, saturating at 16'hFFFF, on every cycle where cpu_wr_valid=1 and cpu_wr_ready=0. It clears only on reset.
- FB_STATS_EN undefined: cpu_stall_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Shared package fb_pkg:
  - ADDR_W, DATA_W, FB_DEPTH constants.
  - Fill state encoding (IDLE=2'd0, FILL=2'd1, DONE=2'd2).
  - Grant-source encoding (GNT_NONE, GNT_VGA, GNT_CPU, GNT_FILL).
- One natural sub-module: fb_fill_engine, containing the fill state machine, counter and colour latch. It exposes a write request, its address and data, and takes a grant input.
- Arbitration and muxing stay in fb_port_arbiter.

Test Plan:
- CPU-only write: cpu_wr_valid=1, addr=100, data=8'h3C, no other requesters -> same cycle cpu_wr_ready=1, mem_we=1, mem_addr=100, mem_wdata=8'h3C.
- VGA priority: vga_req=1, vga_addr=5, cpu_wr_valid=1 for 3 cycles -> cpu_wr_ready=0 and mem_we=0 throughout. vga_rvalid=1 one cycle after each request, with vga_rdata = RAM content at 5. The CPU write completes in the first cycle vga_req=0.
- Fill with FB_DEPTH=16, colour 8'hA5, no contention -> fill_busy high for 16 cycles, addresses 0..15 written with 8'hA5, then one-cycle fill_done, then fill_busy=0.
- CPU vs fill contention: both active for 6 cycles -> grants alternate CPU, FILL, CPU, FILL... The fill finishes 3 writes later than in the uncontended case.
- Out-of-range write to addr=FB_DEPTH, plus a second fill_start while busy -> the write is acked with mem_we=0, and the fill colour and counter are unchanged.
- Reset asserted mid-fill at counter=7 -> fill_busy=0 and vga_rvalid=0 immediately (asynchronous), no fill_done. With FB_STATS_EN, cpu_stall_cnt=0 after reset, and it counts 2 after two stalled cycles.
